// File: rtl/exp_engine_if.sv
// Start/done handshake bundle between the wrapper controller and the e^x engine.
interface exp_engine_if #(
    parameter int unsigned WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] x_in;
    logic             done;
    logic [WIDTH+1:0] result;

    modport master (output start, output x_in, input done, input result);
    modport slave  (input start, input x_in, output done, output result);
endinterface

// File: rtl/exp_engine.sv
// Fixed-point e^x via truncated Taylor series, one shared multiplier, start/done handshake.
// Optional EXP_EARLY_TERM_EN: finish as soon as a truncated term reaches zero.
module exp_engine #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned TERMS = 8
) (
    input logic         clk,
    input logic         rst,
    exp_engine_if.slave eng
);
    localparam int unsigned RW = WIDTH + 2;
    localparam int unsigned PW = 2 * WIDTH + 3;
    localparam logic [RW-1:0] ONE = {2'b01, {WIDTH{1'b0}}};
    localparam logic [3:0] LAST_IDX = 4'(TERMS - 1);

    typedef logic [15:0][WIDTH:0] coef_rom_t;

    // coef[i] = floor(2^WIDTH / i); entry 0 is never addressed
    function automatic coef_rom_t build_rom();
        coef_rom_t rom;
        longint unsigned v;
        rom = '0;
        for (int unsigned k = 1; k < 16; k++) begin
            v = (64'd1 << WIDTH) / 64'(k);
            rom[k] = v[WIDTH:0];
        end
        return rom;
    endfunction

    localparam coef_rom_t COEF = build_rom();

    typedef enum logic [2:0] {IDLE, INIT, MUL_X, MUL_C, ACC} state_t;

    state_t           ps_q, ps_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [RW-1:0]    term_q, term_d;
    logic [RW-1:0]    sum_q, sum_d;
    logic [RW-1:0]    result_q, result_d;
    logic [3:0]       idx_q, idx_d;
    logic             done_q, done_d;

    logic [WIDTH:0]   mul_b;
    logic [PW-1:0]    prod;
    logic [RW-1:0]    prod_sh;
    logic [RW-1:0]    sum_nx;
    logic             last;

    // Shared multiplier: operand B is x in MUL_X, coef[i] otherwise
    assign mul_b   = (ps_q == MUL_C) ? COEF[idx_q] : {1'b0, x_q};
    assign prod    = PW'(term_q) * PW'(mul_b);
    assign prod_sh = RW'(prod >> WIDTH);
    assign sum_nx  = sum_q + term_q;

`ifdef EXP_EARLY_TERM_EN
    assign last = (idx_q == LAST_IDX) || (term_q == '0);
`else
    assign last = (idx_q == LAST_IDX);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ps_q     <= IDLE;
            x_q      <= '0;
            term_q   <= '0;
            sum_q    <= '0;
            result_q <= '0;
            idx_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            ps_q     <= ps_d;
            x_q      <= x_d;
            term_q   <= term_d;
            sum_q    <= sum_d;
            result_q <= result_d;
            idx_q    <= idx_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        ps_d     = ps_q;
        x_d      = x_q;
        term_d   = term_q;
        sum_d    = sum_q;
        result_d = result_q;
        idx_d    = idx_q;
        done_d   = done_q;
        unique case (ps_q)
            IDLE: begin
                if (eng.start) begin
                    x_d    = eng.x_in;
                    done_d = 1'b0;
                    ps_d   = INIT;
                end
            end
            INIT: begin
                term_d = ONE;
                sum_d  = ONE;
                idx_d  = 4'd1;
                ps_d   = MUL_X;
            end
            MUL_X: begin
                term_d = prod_sh;
                ps_d   = MUL_C;
            end
            MUL_C: begin
                term_d = prod_sh;
                ps_d   = ACC;
            end
            ACC: begin
                sum_d = sum_nx;
                if (last) begin
                    result_d = sum_nx;
                    done_d   = 1'b1;
                    ps_d     = IDLE;
                end else begin
                    idx_d = idx_q + 4'd1;
                    ps_d  = MUL_X;
                end
            end
            default: ps_d = IDLE;
        endcase
    end

    assign eng.done   = done_q;
    assign eng.result = result_q;
endmodule

// File: tb/tb_exp_engine.sv
// Directed bench for exp_engine (WIDTH=16, TERMS=8) with hand-computed expectations.
module tb_exp_engine;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;
    int   lat;
    logic [17:0] r;

    exp_engine_if #(.WIDTH(16)) eif ();

    exp_engine #(.WIDTH(16), .TERMS(8)) dut (
        .clk (clk),
        .rst (rst),
        .eng (eif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic check_lat(input string tag, input int l, input int early_exp);
`ifdef EXP_EARLY_TERM_EN
        if (early_exp > 0) check(tag, l, early_exp);
        else check(tag, (l >= 4 && l <= 22) ? 1 : 0, 1);
`else
        check(tag, l, 22);
`endif
    endtask

    // Pulse start with x; optionally inject a busy-time start with another operand.
    task automatic run_op(input logic [15:0] x, input int inject, output int l);
        @(negedge clk);
        eif.x_in  = x;
        eif.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        eif.start = 1'b0;
        check("done_drop", eif.done, 0);
        l = 0;
        for (int k = 1; k <= 100; k++) begin
            if (inject != 0 && k == inject) begin
                eif.start = 1'b1;
                eif.x_in  = ~x;
            end else if (inject != 0 && k == inject + 1) begin
                eif.start = 1'b0;
                eif.x_in  = 16'h1234;
            end
            @(posedge clk);
            @(negedge clk);
            if (eif.done) begin
                l = k;
                break;
            end
        end
        if (l == 0) check("timeout", 0, 1);
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        rst       = 1'b0;
        eif.start = 1'b1;
        eif.x_in  = 16'h5555;

        repeat (3) @(negedge clk);
        check("rst_done", eif.done, 0);
        check("rst_result", eif.result, 0);
        eif.start = 1'b0;
        rst = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_done", eif.done, 0);
        check("idle_result", eif.result, 0);

        run_op(16'h0000, 0, lat);
        check("x0_result", eif.result, 32'h10000);
        check_lat("x0_latency", lat, 4);

        run_op(16'h8000, 0, lat);
        r = eif.result;
        check("x05_range", (r >= 18'h1A603 && r <= 18'h1A613) ? 1 : 0, 1);
        check_lat("x05_latency", lat, 0);
        repeat (6) @(negedge clk);
        check("x05_done_held", eif.done, 1);
        check("x05_result_held", (eif.result >= 18'h1A603 && eif.result <= 18'h1A613) ? 1 : 0, 1);

        run_op(16'hFFFF, 0, lat);
        r = eif.result;
        check("xmax_range", (r >= 18'h2B7C9 && r <= 18'h2B7E1) ? 1 : 0, 1);
        check_lat("xmax_latency", lat, 0);

        run_op(16'h8000, 6, lat);
        r = eif.result;
        check("busy_start_range", (r >= 18'h1A603 && r <= 18'h1A613) ? 1 : 0, 1);
        check_lat("busy_start_latency", lat, 0);

        // start held across completion: done must be high for one cycle only
        @(negedge clk);
        eif.x_in  = 16'h0000;
        eif.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        lat = 0;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (eif.done) begin
                lat = k;
                break;
            end
        end
        if (lat == 0) check("timeout_hold", 0, 1);
        check("hold_result", eif.result, 32'h10000);
        @(negedge clk);
        check("hold_done_one_cycle", eif.done, 0);
        eif.start = 1'b0;
        lat = 0;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (eif.done) begin
                lat = k;
                break;
            end
        end
        if (lat == 0) check("timeout_hold2", 0, 1);

        // reset mid-computation after a nonzero result is on the output
        @(negedge clk);
        eif.x_in  = 16'h8000;
        eif.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        eif.start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_done", eif.done, 0);
        check("midrst_result", eif.result, 0);
        @(negedge clk);
        @(negedge clk);
        check("midrst_result_hold", eif.result, 0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("postrst_idle", eif.done, 0);

        run_op(16'h4000, 0, lat);
        r = eif.result;
        check("x025_range", (r >= 18'h148A5 && r <= 18'h148B5) ? 1 : 0, 1);
        check_lat("x025_latency", lat, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
